// File: rtl/spart_pkg.sv
// Shared constants and state encoding for the SPART serial port.
// SPART_PARITY_EN adds the PARITY state used by 8E1 framing.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] ADDR_DIV_HI = 2'b11;

   localparam int STAT_RDA = 0;
   localparam int STAT_TBR = 1;
   localparam int STAT_FE  = 2;
   localparam int STAT_OVR = 3;
   localparam int STAT_PE  = 4;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
`ifdef SPART_PARITY_EN
      , ST_PARITY
`endif
   } spart_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud divisor: one-cycle tick every (DIV+1) clocks, DIV=0 behaves as 1.
module spart_baud_gen
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_lo,
   input  logic       wr_hi,
   input  logic [7:0] wr_data,
   output logic       tick
);

   localparam logic [15:0] RST_RELOAD = (DEFAULT_DIV == 16'd0) ? 16'd1 : DEFAULT_DIV;

   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] reload;

   always_comb begin
      div_d = div_q;
      if (wr_lo) div_d[7:0]  = wr_data;
      if (wr_hi) div_d[15:8] = wr_data;
      reload = (div_d == 16'd0) ? 16'd1 : div_d;
      cnt_d  = cnt_q - 16'd1;
      // A divisor write restarts the count so the new rate applies immediately
      if (wr_lo || wr_hi || cnt_q == 16'd0) cnt_d = reload;
   end

   assign tick = (cnt_q == 16'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DEFAULT_DIV;
         cnt_q <= RST_RELOAD;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spart_io.sv
// Memory-mapped full-duplex UART (8N1, or 8E1 when SPART_PARITY_EN is defined)
// with 16x oversampled receive and a polled status register.
module spart_io
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIV = 16'd325,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iocs,
   input  logic        read,
   input  logic [1:0]  ioaddr,
   inout  wire  [15:0] databus,
   input  logic        rxd,
   output logic        txd,
   output logic        rda,
   output logic        tbr
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);

   logic        bus_wr, bus_rd, wr_data, rd_data, rd_stat;
   logic        tick, tx_done, tx_go, rxs, rx_ok;
   logic [15:0] status, rd_mux;

   spart_state_e tx_state_q, tx_state_d;
   logic [3:0]   tx_cnt_q, tx_cnt_d;
   logic [2:0]   tx_bit_q, tx_bit_d;
   logic [7:0]   tx_shift_q, tx_shift_d;
   logic         txd_q, txd_d, tbr_q, tbr_d;

   spart_state_e           rx_state_q, rx_state_d;
   logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
   logic                   rx_prev_q, rx_prev_d;
   logic [3:0]             rx_cnt_q, rx_cnt_d;
   logic [2:0]             rx_bit_q, rx_bit_d;
   logic [7:0]             rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
   logic                   rda_q, rda_d, ovr_q, ovr_d, fe_q, fe_d;
`ifdef SPART_PARITY_EN
   logic                   pe_q, pe_d, par_bad_q, par_bad_d;
`endif

   assign bus_wr  = iocs && !read;
   assign bus_rd  = iocs && read;
   assign wr_data = bus_wr && ioaddr == ADDR_DATA;
   assign rd_data = bus_rd && ioaddr == ADDR_DATA;
   assign rd_stat = bus_rd && ioaddr == ADDR_STATUS;

   spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .wr_lo   (bus_wr && ioaddr == ADDR_DIV_LO),
      .wr_hi   (bus_wr && ioaddr == ADDR_DIV_HI),
      .wr_data (databus[7:0]),
      .tick    (tick)
   );

   // tbr rises in the cycle the stop bit ends so a write there chains the next frame
   assign tx_done = tx_state_q == ST_STOP && tick && tx_cnt_q == LAST_TICK;
   assign tbr     = tbr_q || tx_done;
   assign tx_go   = wr_data && tbr;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tbr_d      = tbr_q;
      // txd changes only on ticks so every bit spans exactly OVERSAMPLE ticks
      if (tick && tx_state_q != ST_IDLE) begin
         tx_cnt_d = tx_cnt_q + 4'd1;
         case (tx_state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = tx_shift_q[tx_bit_q];
`ifdef SPART_PARITY_EN
            ST_PARITY: txd_d = ^tx_shift_q;
`endif
            ST_STOP:   txd_d = 1'b1;
            default:   ;
         endcase
         if (tx_cnt_q == LAST_TICK) begin
            case (tx_state_q)
               ST_START: begin
                  tx_state_d = ST_DATA;
                  tx_bit_d   = 3'd0;
               end
               ST_DATA: begin
                  if (tx_bit_q == 3'd7) begin
`ifdef SPART_PARITY_EN
                     tx_state_d = ST_PARITY;
`else
                     tx_state_d = ST_STOP;
`endif
                  end else begin
                     tx_bit_d = tx_bit_q + 3'd1;
                  end
               end
`ifdef SPART_PARITY_EN
               ST_PARITY: tx_state_d = ST_STOP;
`endif
               ST_STOP: begin
                  tx_state_d = ST_IDLE;
                  tbr_d      = 1'b1;
               end
               default: ;
            endcase
         end
      end
      if (tx_go) begin
         tx_state_d = ST_START;
         tx_cnt_d   = 4'd0;
         tx_shift_d = databus[7:0];
         tbr_d      = 1'b0;
      end
   end

   assign rxs = rx_sync_q[SYNC_STAGES-1];

   always_comb begin
      rx_sync_d  = {rx_sync_q[SYNC_STAGES-2:0], rxd};
      rx_prev_d  = rxs;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_buf_d   = rx_buf_q;
      rda_d      = rda_q;
      ovr_d      = ovr_q;
      fe_d       = fe_q;
      rx_ok      = 1'b0;
`ifdef SPART_PARITY_EN
      pe_d       = pe_q;
      par_bad_d  = par_bad_q;
`endif
      if (rd_stat) begin
         ovr_d = 1'b0;
         fe_d  = 1'b0;
`ifdef SPART_PARITY_EN
         pe_d  = 1'b0;
`endif
      end
      if (rx_state_q == ST_IDLE) begin
         if (rx_prev_q && !rxs) begin
            rx_state_d = ST_START;
            rx_cnt_d   = 4'd0;
         end
      end else if (tick) begin
         rx_cnt_d = rx_cnt_q + 4'd1;
         case (rx_state_q)
            ST_START: begin
               if (rx_cnt_q == MID_TICK) begin
                  // Realign so later samples land mid-bit
                  rx_cnt_d   = 4'd0;
                  rx_bit_d   = 3'd0;
                  rx_state_d = rxs ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_cnt_q == LAST_TICK) begin
                  rx_shift_d = {rxs, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) begin
`ifdef SPART_PARITY_EN
                     rx_state_d = ST_PARITY;
`else
                     rx_state_d = ST_STOP;
`endif
                  end else begin
                     rx_bit_d = rx_bit_q + 3'd1;
                  end
               end
            end
`ifdef SPART_PARITY_EN
            ST_PARITY: begin
               if (rx_cnt_q == LAST_TICK) begin
                  par_bad_d  = rxs ^ (^rx_shift_q);
                  rx_state_d = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (rx_cnt_q == LAST_TICK) begin
                  rx_state_d = ST_IDLE;
                  if (!rxs) fe_d = 1'b1;
`ifdef SPART_PARITY_EN
                  else if (par_bad_q) pe_d = 1'b1;
`endif
                  else rx_ok = 1'b1;
               end
            end
            default: rx_state_d = ST_IDLE;
         endcase
      end
      // A data read in the completion cycle consumed the old byte, so no overrun
      if (rx_ok) begin
         rx_buf_d = rx_shift_q;
         rda_d    = 1'b1;
         if (rda_q && !rd_data) ovr_d = 1'b1;
      end else if (rd_data) begin
         rda_d = 1'b0;
      end
   end

   always_comb begin
      status           = 16'h0000;
      status[STAT_RDA] = rda_q;
      status[STAT_TBR] = tbr;
      status[STAT_FE]  = fe_q;
      status[STAT_OVR] = ovr_q;
`ifdef SPART_PARITY_EN
      status[STAT_PE]  = pe_q;
`endif
      rd_mux = (ioaddr == ADDR_DATA) ? {8'h00, rx_buf_q} : status;
   end

   assign databus = (bus_rd && !ioaddr[1]) ? rd_mux : 16'hzzzz;
   assign txd     = txd_q;
   assign rda     = rda_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= 4'd0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         txd_q      <= 1'b1;
         tbr_q      <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_sync_q  <= '1;
         rx_prev_q  <= 1'b1;
         rx_cnt_q   <= 4'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_buf_q   <= 8'h00;
         rda_q      <= 1'b0;
         ovr_q      <= 1'b0;
         fe_q       <= 1'b0;
`ifdef SPART_PARITY_EN
         pe_q       <= 1'b0;
         par_bad_q  <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         tbr_q      <= tbr_d;
         rx_state_q <= rx_state_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_buf_q   <= rx_buf_d;
         rda_q      <= rda_d;
         ovr_q      <= ovr_d;
         fe_q       <= fe_d;
`ifdef SPART_PARITY_EN
         pe_q       <= pe_d;
         par_bad_q  <= par_bad_d;
`endif
      end
   end

endmodule

// File: tb/tb_spart_io.sv
// Directed bench for spart_io in its default 8N1 build, scoreboard-checked.
module tb_spart_io;
   import spart_pkg::*;

   localparam int BIT_CLK = 64;

   logic        clk = 1'b0;
   logic        rst, iocs, read, rxd;
   logic [1:0]  ioaddr;
   wire  [15:0] databus;
   logic        txd, rda, tbr;
   logic        drv_en;
   logic [15:0] drv_val;
   logic [15:0] rd_val;
   logic        start_val;
   int          n, run;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] rx_sb[$];
   logic        tx_sb[$];

   assign databus = drv_en ? drv_val : 16'hzzzz;
   always #5 clk = ~clk;

   spart_io #(.DEFAULT_DIV(16'd325), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .read    (read),
      .ioaddr  (ioaddr),
      .databus (databus),
      .rxd     (rxd),
      .txd     (txd),
      .rda     (rda),
      .tbr     (tbr)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pop_rx();
      if (rx_sb.size() == 0) return 16'hxxxx;
      return rx_sb.pop_front();
   endfunction

   function automatic logic pop_tx();
      if (tx_sb.size() == 0) return 1'bx;
      return tx_sb.pop_front();
   endfunction

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      iocs = 1'b1; read = 1'b1; ioaddr = a;
      #1 d = databus;
      @(posedge clk);
      #1 iocs = 1'b0; read = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] v);
      @(negedge clk);
      iocs = 1'b1; read = 1'b0; ioaddr = a; drv_en = 1'b1; drv_val = v;
      @(posedge clk);
      #1 iocs = 1'b0; drv_en = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_sb.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx_sb.push_back(b[i]);
      tx_sb.push_back(1'b1);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BIT_CLK) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic wait_rda(input int bound);
      int k = 0;
      while (rda !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk("rda_wait", rda, 1'b1);
   endtask

   task automatic wait_fall(input int bound);
      int k = 0;
      while (txd !== 1'b0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk("tx_fall_seen", txd, 1'b0);
   endtask

   task automatic low_run(input int bound, output int len);
      len = 0;
      while (txd === 1'b0 && len < bound) begin
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; iocs = 1'b0; read = 1'b0; ioaddr = 2'b00;
      rxd = 1'b1; drv_en = 1'b0; drv_val = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_rda", rda, 1'b0);
      chk("rst_tbr", tbr, 1'b1);
      rst = 1'b0;

      // Undriven bus: a probe value from the bench must come back untouched
      ioaddr = ADDR_STATUS; drv_en = 1'b1; drv_val = 16'h8000;
      #1 chk("float_unselected", databus, 16'h8000);
      drv_en = 1'b0;
      bus_read(ADDR_STATUS, rd_val);
      chk("rst_status", rd_val, 16'h0002);
      @(negedge clk);
      iocs = 1'b1; read = 1'b1; ioaddr = ADDR_DIV_LO; drv_en = 1'b1; drv_val = 16'h8000;
      #1 chk("float_div_read", databus, 16'h8000);
      @(posedge clk);
      #1 iocs = 1'b0; read = 1'b0; drv_en = 1'b0;

      // Transmit 0xA5 at divisor 3 (64 clocks per bit)
      bus_write(ADDR_DIV_LO, 16'h0003);
      bus_write(ADDR_DIV_HI, 16'h0000);
      push_tx(8'hA5);
      bus_write(ADDR_DATA, 16'h00A5);
      chk("tx_tbr_busy", tbr, 1'b0);
      wait_fall(200);
      start_val = txd;
      chk("tx_start_bit", start_val, pop_tx());
      low_run(200, run);
      chk("tx_start_len", run[15:0], 16'd64);
      repeat (BIT_CLK / 2) @(negedge clk);
      for (int k = 1; k < 10; k++) begin
         chk($sformatf("tx_bit%0d", k), txd, pop_tx());
         repeat (BIT_CLK) @(negedge clk);
      end
      chk("tx_tbr_done", tbr, 1'b1);
      chk("tx_idle_high", txd, 1'b1);
      chk("tx_sb_empty", tx_sb.size(), 16'd0);

      // Receive 0x3C
      rx_sb.push_back(16'h003C);
      send_rx(8'h3C, 1'b1);
      wait_rda(200);
      bus_read(ADDR_DATA, rd_val);
      chk("rx_data", rd_val, pop_rx());
      chk("rx_rda_cleared", rda, 1'b0);

      // Two bytes without a read: the second overwrites and flags overrun
      send_rx(8'h11, 1'b1);
      rx_sb.push_back(16'h0022);
      send_rx(8'h22, 1'b1);
      wait_rda(200);
      bus_read(ADDR_STATUS, rd_val);
      chk("ovr_status", rd_val, 16'h000B);
      bus_read(ADDR_DATA, rd_val);
      chk("ovr_data", rd_val, pop_rx());
      bus_read(ADDR_STATUS, rd_val);
      chk("ovr_cleared", rd_val, 16'h0002);

      // Short low glitch is a false start
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rxd = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_rda", rda, 1'b0);
      bus_read(ADDR_STATUS, rd_val);
      chk("glitch_status", rd_val, 16'h0002);

      // Stop bit low: frame error, byte discarded
      send_rx(8'h55, 1'b0);
      repeat (100) @(negedge clk);
      chk("fe_rda", rda, 1'b0);
      bus_read(ADDR_STATUS, rd_val);
      chk("fe_status", rd_val, 16'h0006);
      bus_read(ADDR_STATUS, rd_val);
      chk("fe_cleared", rd_val, 16'h0002);
      chk("rx_sb_empty", rx_sb.size(), 16'd0);

      // Reset in the middle of data bit 4 of 0xA5
      bus_write(ADDR_DATA, 16'h00A5);
      wait_fall(200);
      repeat (BIT_CLK * 5 + BIT_CLK / 2) @(negedge clk);
      chk("tx_bit4_pre_rst", txd, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_txd", txd, 1'b1);
      chk("mid_rst_tbr", tbr, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // Default divisor again: start bit spans 16 * 326 clocks
      bus_write(ADDR_DATA, 16'h0001);
      wait_fall(1000);
      low_run(6000, run);
      chk("default_div_len", run[15:0], 16'd5216);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spart_io.md
Name: spart_io

Overview:
- Memory-mapped serial port (SPART) on the shared 16-bit CPU data bus.
- Selected by the address decoder's spart chip select, alongside the graphics, audio and PS/2 peripherals; runs on the CPU clock.
- Full-duplex 8N1 UART with a programmable baud divisor, 16x oversampled receive, and a status register polled by software.

Parameters:
- DEFAULT_DIV, 16'd325, reset divisor; one baud tick = (DIV+1) clk cycles; 16 ticks per bit (9600 baud at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the rxd synchroniser.

Ports:
- clk  in  1  CPU clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- iocs  in  1  chip select from the address decoder.
- read  in  1  1 = CPU read cycle, 0 = write cycle (valid when iocs=1).
- ioaddr  in  2  register select: 00 data, 01 status, 10 divisor low, 11 divisor high.
- databus  inout  16  shared bus; driven only during a selected read, Z otherwise.
- rxd  in  1  serial receive, asynchronous to clk.
- txd  out  1  serial transmit, idle high.
- rda  out  1  receive data available.
- tbr  out  1  transmit buffer ready.

Behaviour:
- Reset values (applied on the next clk edge with rst=1):
  - txd=1, rda=0, tbr=1.
  - Divisor=DEFAULT_DIV; error flags=0; both FSMs in IDLE; rx buffer=0.
  - Reset mid-frame abandons the frame; txd returns high at that edge.
- Bus reads:
  - When iocs&read and ioaddr is 00 or 01, databus is driven combinationally in the same cycle.
  - Otherwise databus is Z, including all reads of 10/11 (write-only).
  - 00 returns {8'h00, rx_buf}. A read of 00 clears rda at the next edge.
  - 01 returns {12'h0, overrun, frame_err, tbr, rda}. A read of 01 clears overrun and frame_err at the next edge.
- Bus writes (iocs & ~read):
  - 00 with tbr=1: latches databus[7:0] and starts TX; tbr=0 from the next edge. With tbr=0 the write is ignored.
  - 10 / 11: load divisor[7:0] / divisor[15:8] from databus[7:0]. The baud counter reloads at the next edge.
  - Divisor 0 is treated as 1.
- Baud generator:
  - Down-counter from divisor; emits a 1-cycle tick at 0, then reloads.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START, each DATA bit and STOP each last exactly 16 ticks.
  - DATA sends LSB first; a 3-bit counter runs 0..7.
  - txd is registered.
  - tbr returns to 1 in the cycle STOP completes. A write in that same cycle is accepted.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, using the synchronised rxd.
  - IDLE -> START on a falling edge.
  - At tick 8 of START: if rxd=1 it is a false start; go back to IDLE with no flags set.
  - Data bits are sampled every 16 ticks thereafter.
  - STOP sample = 0: set frame_err and discard the byte (rx_buf and rda unchanged).
  - STOP sample = 1: write rx_buf and set rda.
- Receive boundary cases:
  - A valid byte completes while rda=1: overwrite rx_buf, set overrun.
  - A byte completes in the same cycle as a read of 00: the bus returns the old byte, rda stays 1, no overrun.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro SPART_PARITY_EN.
- Defined:
  - Frames are 8E1.
  - TX inserts an even-parity bit (XOR of data) between DATA and STOP, in a PARITY state lasting 16 ticks.
  - RX checks the parity bit. On mismatch it sets status bit 4 (parity_err) and discards the byte. Bit 4 clears on a status read.
- Not defined: 8N1 only; status bit 4 reads 0; no PARITY state exists.

Decomposition:
- Package spart_pkg:
  - Register address constants ADDR_DATA/ADDR_STATUS/ADDR_DIV_LO/ADDR_DIV_HI.
  - Status bit index constants.
  - Shared TX/RX state enum typedef.
  - OVERSAMPLE=16 and MID_SAMPLE=8 constants.
- Sub-module spart_baud_gen: divisor register load, down-counter and tick output.
- TX, RX and the bus interface stay in spart_io.

Test Plan:
- Reset, then read status -> databus = 16'h0002 (tbr=1), txd=1, databus Z when iocs=0.
- Write divisor 0x0003, then write 0x00A5 to data -> txd low for 64 clk, then bits 1,0,1,0,0,1,0,1 each 64 clk, then high 64 clk; tbr=1 afterwards.
- Drive rxd with 0x3C at divisor 3 -> rda=1 after stop; read 00 returns 16'h003C; rda=0 next cycle.
- Send two bytes 0x11, 0x22 without reading -> status = 16'h000B (overrun, tbr, rda); data reads 0x22; the next status read shows overrun cleared.
- rxd low glitch of 20 clk at divisor 3 -> no rda and no flags. A frame with stop bit 0 -> frame_err=1, rda stays 0.
- Assert rst mid-TX at bit 4 -> txd=1 and tbr=1 at the next edge, divisor back to DEFAULT_DIV.
